gpio_pixel_streamer: RTL and testbench

Consumes the per-channel GPIO store port of the data memory (32-bit word plus R/G/B enables, scalar or vector store) and delivers the stored pixel bytes to the off-chip host link as a byte stream with a valid/ready handshake. A small FIFO absorbs processor store bursts. A serializer FSM splits each buffered word into 1 byte (scalar store) or 4 bytes (vector store), tagged with colour channel and end-of-word.

---
 rtl/dm_gpio_pkg.sv | 24 ++
 rtl/gpio_sync_fifo.sv | 51 +++++
 rtl/gpio_pixel_streamer.sv | 138 +++++++++++++
 tb/tb_gpio_pixel_streamer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/dm_gpio_pkg.sv
// Types shared by the GPIO pixel streamer: colour channel codes, the buffered
// store entry and the serializer state encoding.
package dm_gpio_pkg;

  typedef enum logic [1:0] {
    CH_R = 2'd0,
    CH_G = 2'd1,
    CH_B = 2'd2
  } chan_e;

  typedef struct packed {
    chan_e       chan;
    logic        vf;
    logic [31:0] data;
  } gpio_entry_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_e;

  localparam int ENTRY_W = $bits(gpio_entry_t);

endpackage

// File: rtl/gpio_sync_fifo.sv
// Single-clock FIFO with a flop-array store; the head entry is read straight
// from the array so a pop and the following reload happen on the same edge.
module gpio_sync_fifo #(
  parameter int WIDTH = 35,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   LVL_ONE  = 1;
  localparam logic [AW:0]   FULL_LVL = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  assign rd_data = mem[rd_ptr];
  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);

  // Storage carries no reset; only pointers and level define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop)      level <= level + LVL_ONE;
      else if (pop && !push) level <= level - LVL_ONE;
    end
  end

endmodule

// File: rtl/gpio_pixel_streamer.sv
// Turns per-channel GPIO stores into a tagged byte stream on a valid/ready
// host link, buffering store bursts in a small FIFO.
module gpio_pixel_streamer
  import dm_gpio_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            GPIO,
  input  logic                   GPIOEnR,
  input  logic                   GPIOEnG,
  input  logic                   GPIOEnB,
  input  logic                   gpio_vf,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7:0]             out_data,
  output logic [1:0]             out_chan,
  output logic                   out_last,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   overflow,
  output logic                   protocol_err,
  output logic [0:0]             ser_state
);

  // Handshake: a byte transfers on a rising edge where out_valid && out_ready;
  // while out_valid && !out_ready the data and tags do not change.

  localparam logic [0:0] ST_IDLE = IDLE;
  localparam logic [0:0] ST_SEND = SEND;

  logic [1:0]   en_cnt;
  logic         one_hot;
  logic         multi_en;
  gpio_entry_t  wr_entry;
  gpio_entry_t  head;
  logic [ENTRY_W-1:0] head_bits;
  logic         fifo_push;
  logic         fifo_full;
  logic         fifo_empty;
  logic         ser_pop;

  logic [0:0]   state;
  logic [31:0]  cur_data;
  logic [1:0]   cur_chan;
  logic [1:0]   idx;
  logic [1:0]   last_idx;

  assign en_cnt   = {1'b0, GPIOEnR} + {1'b0, GPIOEnG} + {1'b0, GPIOEnB};
  assign one_hot  = (en_cnt == 2'd1);
  assign multi_en = (en_cnt >= 2'd2);

  always_comb begin
    wr_entry      = '0;
    wr_entry.chan = GPIOEnR ? CH_R : (GPIOEnG ? CH_G : CH_B);
    wr_entry.vf   = gpio_vf;
    wr_entry.data = GPIO;
  end

  assign head = gpio_entry_t'(head_bits);

  // The serializer pulls the next word either from IDLE or as the final byte
  // of the current word is accepted, so consecutive words have no bubble.
  assign ser_pop = !fifo_empty &&
                   ((state == ST_IDLE) ||
                    (out_ready && (idx == last_idx)));

  assign fifo_push = !rst && one_hot && (!fifo_full || ser_pop);

  gpio_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .wr_data (wr_entry),
    .pop     (ser_pop),
    .rd_data (head_bits),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow     <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      if (one_hot && fifo_full && !ser_pop) overflow <= 1'b1;
      if (multi_en)                         protocol_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cur_data <= '0;
      cur_chan <= '0;
      idx      <= '0;
      last_idx <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ser_pop) begin
            cur_data <= head.data;
            cur_chan <= head.chan;
            idx      <= 2'd0;
            last_idx <= head.vf ? 2'd3 : 2'd0;
            state    <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (out_ready) begin
            if (idx != last_idx) begin
              idx <= idx + 2'd1;
            end else if (ser_pop) begin
              cur_data <= head.data;
              cur_chan <= head.chan;
              idx      <= 2'd0;
              last_idx <= head.vf ? 2'd3 : 2'd0;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign out_valid = (state == ST_SEND);
  assign out_data  = cur_data[{idx, 3'b000} +: 8];
  assign out_chan  = cur_chan;
  assign out_last  = out_valid && (idx == last_idx);
  assign ser_state = state;

endmodule

// File: tb/tb_gpio_pixel_streamer.sv
// Directed bench for gpio_pixel_streamer: scalar/vector streaming, stalls,
// overflow, protocol errors and reset mid-word.
module tb_gpio_pixel_streamer;

  logic        clk;
  logic        rst;
  logic [31:0] GPIO;
  logic        GPIOEnR, GPIOEnG, GPIOEnB;
  logic        gpio_vf;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_chan;
  logic        out_last;
  logic [3:0]  fifo_level;
  logic        overflow;
  logic        protocol_err;
  logic [0:0]  ser_state;

  int n_cmp;
  int n_fail;
  // {chan, last, data}
  logic [10:0] exp_q[$];
  logic [10:0] obs_q[$];

  gpio_pixel_streamer #(.DEPTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .GPIO         (GPIO),
    .GPIOEnR      (GPIOEnR),
    .GPIOEnG      (GPIOEnG),
    .GPIOEnB      (GPIOEnB),
    .gpio_vf      (gpio_vf),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_chan     (out_chan),
    .out_last     (out_last),
    .fifo_level   (fifo_level),
    .overflow     (overflow),
    .protocol_err (protocol_err),
    .ser_state    (ser_state)
  );

  // clock/reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] d, input logic r, input logic g,
                       input logic b, input logic vf);
    GPIO = d; GPIOEnR = r; GPIOEnG = g; GPIOEnB = b; gpio_vf = vf;
    step();
    GPIOEnR = 1'b0; GPIOEnG = 1'b0; GPIOEnB = 1'b0; gpio_vf = 1'b0;
  endtask

  task automatic collect(input int n, input int budget);
    int got;
    int cyc;
    got = 0;
    cyc = 0;
    obs_q.delete();
    while (got < n && cyc < budget) begin
      if (out_valid && out_ready) begin
        obs_q.push_back({out_chan, out_last, out_data});
        got++;
      end
      step();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; out_ready = 1'b0; GPIO = 32'hDEADBEEF;
    GPIOEnR = 1'b1; GPIOEnG = 1'b0; GPIOEnB = 1'b0; gpio_vf = 1'b1;
    step(); step();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", out_data); end
    n_cmp++; if (out_chan !== 2'd0) begin n_fail++; $display("FAIL reset_chan: got %0d want 0", out_chan); end
    n_cmp++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b want 0", out_last); end
    n_cmp++; if (fifo_level !== 4'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
    n_cmp++; if ({overflow, protocol_err} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b want 00", {overflow, protocol_err}); end
    n_cmp++; if (ser_state !== 1'b0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", ser_state); end
    rst = 1'b0; GPIOEnR = 1'b0; gpio_vf = 1'b0;
    step();
    n_cmp++; if ({out_valid, fifo_level} !== 5'd0) begin n_fail++; $display("FAIL reset_store_ignored: got valid=%b level=%0d want 0/0", out_valid, fifo_level); end
  endtask

  task automatic test_scalar();
    out_ready = 1'b1;
    store(32'h000000A5, 1'b0, 1'b1, 1'b0, 1'b0);
    n_cmp++; if ({out_valid, fifo_level} !== {1'b0, 4'd1}) begin n_fail++; $display("FAIL scalar_queued: got valid=%b level=%0d want 0/1", out_valid, fifo_level); end
    step();
    n_cmp++; if ({out_valid, out_data, out_chan, out_last} !== {1'b1, 8'hA5, 2'd1, 1'b1}) begin
      n_fail++; $display("FAIL scalar_byte: got v=%b d=%h c=%0d l=%b want 1/a5/1/1", out_valid, out_data, out_chan, out_last); end
    step();
    n_cmp++; if ({out_valid, fifo_level} !== 5'd0) begin n_fail++; $display("FAIL scalar_idle: got valid=%b level=%0d want 0/0", out_valid, fifo_level); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    GPIO = 32'h44332211; GPIOEnR = 1'b1; gpio_vf = 1'b1;
    step();
    GPIO = 32'h88776655; GPIOEnR = 1'b0; GPIOEnB = 1'b1;
    step();
    GPIOEnB = 1'b0; gpio_vf = 1'b0;
    exp_q.delete();
    exp_q.push_back({2'd0, 1'b0, 8'h11}); exp_q.push_back({2'd0, 1'b0, 8'h22});
    exp_q.push_back({2'd0, 1'b0, 8'h33}); exp_q.push_back({2'd0, 1'b1, 8'h44});
    exp_q.push_back({2'd2, 1'b0, 8'h55}); exp_q.push_back({2'd2, 1'b0, 8'h66});
    exp_q.push_back({2'd2, 1'b0, 8'h77}); exp_q.push_back({2'd2, 1'b1, 8'h88});
    // eight bytes in eight cycles: any bubble leaves the stream short
    collect(8, 8);
    n_cmp++; if (obs_q.size() != 8) begin n_fail++; $display("FAIL b2b_count: got %0d want 8", obs_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [10:0] got;
      got = (i < obs_q.size()) ? obs_q[i] : 'x;
      n_cmp++; if (got !== exp_q[i]) begin n_fail++; $display("FAIL b2b_byte%0d: got %h want %h", i, got, exp_q[i]); end
    end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got %b want 0", out_valid); end
  endtask

  task automatic test_stall();
    out_ready = 1'b1;
    store(32'hDDCCBBAA, 1'b0, 1'b1, 1'b0, 1'b1);
    step();
    n_cmp++; if ({out_valid, out_data, out_chan, out_last} !== {1'b1, 8'hAA, 2'd1, 1'b0}) begin
      n_fail++; $display("FAIL stall_first: got v=%b d=%h c=%0d l=%b want 1/aa/1/0", out_valid, out_data, out_chan, out_last); end
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++; if ({out_valid, out_data, out_chan, out_last} !== {1'b1, 8'hBB, 2'd1, 1'b0}) begin
        n_fail++; $display("FAIL stall_hold%0d: got v=%b d=%h c=%0d l=%b want 1/bb/1/0", i, out_valid, out_data, out_chan, out_last); end
    end
    out_ready = 1'b1;
    exp_q.delete();
    exp_q.push_back({2'd1, 1'b0, 8'hBB});
    exp_q.push_back({2'd1, 1'b0, 8'hCC});
    exp_q.push_back({2'd1, 1'b1, 8'hDD});
    collect(3, 10);
    n_cmp++; if (obs_q.size() != 3) begin n_fail++; $display("FAIL stall_count: got %0d want 3", obs_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [10:0] got;
      got = (i < obs_q.size()) ? obs_q[i] : 'x;
      n_cmp++; if (got !== exp_q[i]) begin n_fail++; $display("FAIL stall_byte%0d: got %h want %h", i, got, exp_q[i]); end
    end
  endtask

  task automatic test_protocol_err();
    out_ready = 1'b1;
    n_cmp++; if (protocol_err !== 1'b0) begin n_fail++; $display("FAIL proto_pre: got %b want 0", protocol_err); end
    store(32'h12345678, 1'b1, 1'b0, 1'b1, 1'b1);
    n_cmp++; if ({protocol_err, fifo_level} !== {1'b1, 4'd0}) begin n_fail++; $display("FAIL proto_flag: got err=%b level=%0d want 1/0", protocol_err, fifo_level); end
    step();
    n_cmp++; if ({out_valid, protocol_err, overflow} !== 3'b010) begin n_fail++; $display("FAIL proto_sticky: got v=%b err=%b ovf=%b want 0/1/0", out_valid, protocol_err, overflow); end
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    // first word moves into the serializer, so the FIFO fills after nine stores
    for (int i = 0; i < 10; i++) begin
      logic [31:0] w;
      for (int j = 0; j < 4; j++) w[8*j +: 8] = 8'(16 + 4*i + j);
      store(w, 1'b1, 1'b0, 1'b0, 1'b1);
      if (i == 8) begin
        n_cmp++; if ({fifo_level, overflow} !== {4'd8, 1'b0}) begin n_fail++; $display("FAIL ovf_full: got level=%0d ovf=%b want 8/0", fifo_level, overflow); end
      end
    end
    n_cmp++; if ({fifo_level, overflow} !== {4'd8, 1'b1}) begin n_fail++; $display("FAIL ovf_drop: got level=%0d ovf=%b want 8/1", fifo_level, overflow); end
    out_ready = 1'b1;
    exp_q.delete();
    for (int b = 0; b < 36; b++) exp_q.push_back({2'd0, (b % 4) == 3, 8'(16 + b)});
    collect(36, 60);
    n_cmp++; if (obs_q.size() != 36) begin n_fail++; $display("FAIL ovf_count: got %0d want 36", obs_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [10:0] got;
      got = (i < obs_q.size()) ? obs_q[i] : 'x;
      n_cmp++; if (got !== exp_q[i]) begin n_fail++; $display("FAIL ovf_byte%0d: got %h want %h", i, got, exp_q[i]); end
    end
    step();
    n_cmp++; if ({out_valid, fifo_level, overflow} !== {1'b0, 4'd0, 1'b1}) begin
      n_fail++; $display("FAIL ovf_drained: got v=%b level=%0d ovf=%b want 0/0/1", out_valid, fifo_level, overflow); end
  endtask

  task automatic test_rst_mid_word();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) store({8'(8'h43 + 4*i), 8'(8'h42 + 4*i), 8'(8'h41 + 4*i), 8'(8'h40 + 4*i)}, 1'b0, 1'b1, 1'b0, 1'b1);
    n_cmp++; if ({out_valid, out_data, fifo_level} !== {1'b1, 8'h40, 4'd3}) begin n_fail++; $display("FAIL rstw_queued: got v=%b d=%h level=%0d want 1/40/3", out_valid, out_data, fifo_level); end
    out_ready = 1'b1;
    step();
    n_cmp++; if (out_data !== 8'h41) begin n_fail++; $display("FAIL rstw_byte1: got %h want 41", out_data); end
    rst = 1'b1; GPIO = 32'hCAFEF00D; GPIOEnR = 1'b1;
    step();
    n_cmp++; if ({out_valid, fifo_level, overflow, protocol_err, ser_state} !== 8'd0) begin
      n_fail++; $display("FAIL rstw_cleared: got v=%b level=%0d ovf=%b err=%b st=%0d want all 0", out_valid, fifo_level, overflow, protocol_err, ser_state); end
    rst = 1'b0; GPIOEnR = 1'b0;
    step(); step();
    n_cmp++; if ({out_valid, fifo_level} !== 5'd0) begin n_fail++; $display("FAIL rstw_discard: got v=%b level=%0d want 0/0", out_valid, fifo_level); end
    store(32'h12345677, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    n_cmp++; if ({out_valid, out_data, out_chan, out_last} !== {1'b1, 8'h77, 2'd2, 1'b1}) begin
      n_fail++; $display("FAIL rstw_new: got v=%b d=%h c=%0d l=%b want 1/77/2/1", out_valid, out_data, out_chan, out_last); end
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstw_new_idle: got %b want 0", out_valid); end
  endtask

  // sequence and final report
  initial begin
    n_cmp = 0;
    n_fail = 0;
    test_reset();
    test_scalar();
    test_back_to_back();
    test_stall();
    test_protocol_err();
    test_overflow();
    test_rst_mid_word();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
